clk_div_param: RTL and testbench

CLK_DIV_PARAM -- requirements
Module: clk_div_param

---
 rtl/clk_div_param.sv | 141 ++++++++++++++
 tb/tb_clk_div_param.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_param.sv
// Integer clock divider with bypass, period-boundary ratio updates and tick/ack pulses.
// Define CLK_DIV_ODD_DUTY50_EN to stretch odd-ratio high phases by half a ref cycle (exact 50% duty).
module clk_div_param #(
    parameter int RATIO_WIDTH = 8
) (
    input  logic                   I_ref_clk,
    input  logic                   I_rst_n,
    input  logic                   I_clk_en,
    input  logic [RATIO_WIDTH-1:0] I_div_ratio,
    output logic                   O_div_clk,
    output logic                   O_period_tick,
    output logic                   O_ratio_ack,
    output logic                   O_bypass
);

    // state   | meaning
    // BYPASS  | ref clock passed straight through, waiting for enable and ratio >= 2
    // HIGH    | divided clock high, cnt counts 1..H
    // LOW     | divided clock low, cnt counts 1..L; cnt == L is the period boundary
    typedef enum logic [1:0] {
        ST_BYPASS = 2'd0,
        ST_HIGH   = 2'd1,
        ST_LOW    = 2'd2
    } state_t;

    localparam logic [RATIO_WIDTH-1:0] CNT_ONE = RATIO_WIDTH'(1);
    localparam logic [RATIO_WIDTH-1:0] MIN_RATIO = RATIO_WIDTH'(2);

    state_t                 state_q, state_d;
    logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
    logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
    logic                   div_q, div_d;
    logic                   tick_q, tick_d;
    logic                   ack_q, ack_d;
    logic                   bypass_q, bypass_d;

    logic [RATIO_WIDTH-1:0] half_len;
    logic [RATIO_WIDTH-1:0] low_len;
    logic                   start_ok;
    logic                   div_active;

    assign half_len = ratio_q >> 1;
    assign low_len  = ratio_q - half_len;
    assign start_ok = I_clk_en && (I_div_ratio >= MIN_RATIO);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        ack_d   = 1'b0;
        case (state_q)
            ST_BYPASS: begin
                if (start_ok) begin
                    state_d = ST_HIGH;
                    ratio_d = I_div_ratio;
                    cnt_d   = CNT_ONE;
                    div_d   = 1'b1;
                    tick_d  = 1'b1;
                    ack_d   = 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_q == half_len) begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_ONE;
                    div_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LOW: begin
                if (cnt_q != low_len) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (start_ok) begin
                    // Boundary restart: ack only when the ratio actually changes
                    state_d = ST_HIGH;
                    ratio_d = I_div_ratio;
                    cnt_d   = CNT_ONE;
                    div_d   = 1'b1;
                    tick_d  = 1'b1;
                    ack_d   = (I_div_ratio != ratio_q);
                end else begin
                    state_d = ST_BYPASS;
                    cnt_d   = '0;
                    div_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_BYPASS;
                cnt_d   = '0;
                div_d   = 1'b0;
            end
        endcase
        bypass_d = (state_d == ST_BYPASS);
    end

    always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q  <= ST_BYPASS;
            cnt_q    <= '0;
            ratio_q  <= '0;
            div_q    <= 1'b0;
            tick_q   <= 1'b0;
            ack_q    <= 1'b0;
            bypass_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ratio_q  <= ratio_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            ack_q    <= ack_d;
            bypass_q <= bypass_d;
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic div_neg_q;

    always_ff @(negedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            div_neg_q <= 1'b0;
        end else begin
            div_neg_q <= div_q;
        end
    end

    assign div_active = ratio_q[0] ? (div_q | div_neg_q) : div_q;
`else
    assign div_active = div_q;
`endif

    // Bypass path is gated by reset so the output is quiet while held in reset
    assign O_div_clk     = bypass_q ? (I_ref_clk & I_rst_n) : div_active;
    assign O_period_tick = tick_q;
    assign O_ratio_ack   = ack_q;
    assign O_bypass      = bypass_q;

endmodule

// File: tb/tb_clk_div_param.sv
// Scoreboard bench for clk_div_param: period-level reference model feeds a queue,
// a monitor pops one expected record per ref cycle and compares.
module tb_clk_div_param;

    localparam int W = 8;

    typedef struct packed {
        logic byp;
        logic div;
        logic tick;
        logic ack;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clk_en = 1'b0;
    logic [W-1:0] div_ratio = W'(1);
    logic         div_clk, period_tick, ratio_ack, bypass;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];

    // reference model: either bypassing, or inside a period that began at edge m_s with ratio m_r
    bit m_byp = 1'b1;
    int m_s   = 0;
    int m_r   = 0;
    bit m_ack = 1'b0;
    int k     = 0;

    clk_div_param #(.RATIO_WIDTH(W)) dut (
        .I_ref_clk    (clk),
        .I_rst_n      (rst_n),
        .I_clk_en     (clk_en),
        .I_div_ratio  (div_ratio),
        .O_div_clk    (div_clk),
        .O_period_tick(period_tick),
        .O_ratio_ack  (ratio_ack),
        .O_bypass     (bypass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at t=%0t (edge %0d)", name, act, exp_v, $time, k);
        end
    endtask

    // one ref cycle: drive inputs at the falling edge, predict the outputs after the next rising edge
    task automatic step(input logic en, input int r);
        exp_t e;
        int   o;
        int   hi;
        @(negedge clk);
        clk_en    = en;
        div_ratio = W'(r);
        k++;
        if (m_byp || (k == m_s + m_r)) begin
            if (en && r >= 2) begin
                m_ack = m_byp ? 1'b1 : (r != m_r);
                m_byp = 1'b0;
                m_s   = k;
                m_r   = r;
            end else begin
                m_byp = 1'b1;
            end
        end
        if (m_byp) begin
            e = '{byp: 1'b1, div: 1'b1, tick: 1'b0, ack: 1'b0};
        end else begin
            o  = k - m_s;
            hi = m_r / 2;
`ifdef CLK_DIV_ODD_DUTY50_EN
            // sampled just after the rising edge, the half-cycle extension still shows high
            if (m_r % 2 == 1) hi = hi + 1;
`endif
            e.byp  = 1'b0;
            e.div  = (o < hi);
            e.tick = (o == 0);
            e.ack  = (o == 0) && m_ack;
        end
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("bypass", bypass, e.byp);
            chk("div_clk", div_clk, e.div);
            chk("period_tick", period_tick, e.tick);
            chk("ratio_ack", ratio_ack, e.ack);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int hold;
        int r;
        logic en;

        // reset values, sampled while ref clock is high to show the gated bypass
        #7;
        chk("rst_div_clk", div_clk, 1'b0);
        chk("rst_bypass", bypass, 1'b1);
        chk("rst_tick", period_tick, 1'b0);
        chk("rst_ack", ratio_ack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) step(1'b0, 1);
        for (int i = 0; i < 16; i++) step(1'b1, 4);

        // ratio 4 -> 6 presented during the second cycle of a high phase
        guard = 0;
        do begin
            step(1'b1, 4);
            guard++;
        end while (!(!m_byp && k == m_s) && guard < 20);
        chk("align_ratio4", guard < 20, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 6);

        for (int i = 0; i < 20; i++) step(1'b1, 5);

        // longest ratio, then disable mid-period: period must finish before bypass
        for (int i = 0; i < 100; i++) step(1'b1, 255);
        for (int i = 0; i < 300; i++) step(1'b0, 255);

        // async reset in the low phase of ratio 6
        guard = 0;
        do begin
            step(1'b1, 6);
            guard++;
        end while (!(!m_byp && (k - m_s) == 4) && guard < 20);
        chk("align_ratio6_low", guard < 20, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_div_clk", div_clk, 1'b0);
        chk("midrst_bypass", bypass, 1'b1);
        chk("midrst_tick", period_tick, 1'b0);
        chk("midrst_ack", ratio_ack, 1'b0);
        @(negedge clk);
        clk_en = 1'b0;
        @(posedge clk);
        #1;
        chk("inrst_div_clk", div_clk, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_byp = 1'b1;
        for (int i = 0; i < 15; i++) step(1'b1, 6);

        // randomized ratio/enable changes, each held a random number of cycles
        for (int n = 0; n < 40; n++) begin
            r    = $urandom_range(0, 12);
            en   = ($urandom_range(0, 7) != 0);
            hold = $urandom_range(1, 25);
            for (int i = 0; i < hold; i++) step(en, r);
        end

        for (int i = 0; i < 20; i++) step(1'b0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", q.size() == 0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
